// File: rtl/systolic_pkg.sv
// Shared types and lane-slicing helpers for the systolic array sequencer.
package systolic_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Lane 0 occupies the most-significant word of a packed lane vector.
  function automatic int lane_lsb(input int lane, input int dim, input int w);
    return (dim - 1 - lane) * w;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Depth-stage data+valid delay line; invalid words leave the line as zero.
module skew_line
  import systolic_pkg::*;
#(
  parameter int depth     = 1,
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic [word_size-1:0] out_data,
  output logic                 out_valid
);

  generate
    if (depth == 0) begin : g_wire
      assign out_data  = in_valid ? in_data : '0;
      assign out_valid = in_valid;
    end else begin : g_regs
      logic [word_size-1:0] data_reg [depth];
      logic [depth-1:0]     valid_reg;

      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
          for (int s = 0; s < depth; s++) data_reg[s] <= '0;
          valid_reg <= '0;
        end else begin
          data_reg[0]  <= in_valid ? in_data : '0;
          valid_reg[0] <= in_valid;
          for (int s = 1; s < depth; s++) begin
            data_reg[s]  <= data_reg[s-1];
            valid_reg[s] <= valid_reg[s-1];
          end
        end
      end

      assign out_data  = valid_reg[depth-1] ? data_reg[depth-1] : '0;
      assign out_valid = valid_reg[depth-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary systolic array: clear, skewed operand
// streaming from the A/B buffers, wavefront drain and completion flagging.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int word_size = 16,
  parameter int array_dim = 4,
  parameter int k_width   = 8
) (
  input  logic                           clk,
  input  logic                           clear_n,
  input  logic                           start,
  input  logic [k_width-1:0]             k_len,
  output logic                           busy,
  output logic                           done,
  output logic                           result_valid,
  output logic                           rd_en,
  output logic [k_width-1:0]             rd_addr,
  input  logic [array_dim*word_size-1:0] a_rd_data,
  input  logic [array_dim*word_size-1:0] b_rd_data,
  output logic [array_dim*word_size-1:0] array_a,
  output logic [array_dim*word_size-1:0] array_b,
  output logic                           array_clear
);

  localparam int DRAIN_CYCLES = 2 * (array_dim - 1);
  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t               state_reg, state_next;
  logic [k_width-1:0]   k_reg;
  logic [k_width-1:0]   k_cnt_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg;
  logic                 result_valid_reg;
  logic [k_width:0]     k_next_idx;
  logic                 feed_valid;
  logic                 stream_phase;
  logic [array_dim*word_size-1:0] a_gated, b_gated;

  assign k_next_idx = {1'b0, k_cnt_reg} + (k_width+1)'(1);

  always_comb begin
    state_next  = state_reg;
    rd_en       = 1'b0;
    rd_addr     = '0;
    array_clear = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        array_clear = 1'b1;
        rd_en       = 1'b1;
        state_next  = (k_reg == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        // Prefetch the next vector so data lands exactly one cycle later.
        if (k_next_idx < {1'b0, k_reg}) begin
          rd_en   = 1'b1;
          rd_addr = k_next_idx[k_width-1:0];
        end
        if (k_cnt_reg == k_reg - k_width'(1))
          state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_reg        <= ST_IDLE;
      k_reg            <= '0;
      k_cnt_reg        <= '0;
      drain_cnt_reg    <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) k_reg <= k_len;
      k_cnt_reg     <= (state_reg == ST_FEED)  ? k_cnt_reg + k_width'(1)     : '0;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + DRAIN_W'(1) : '0;
      if (state_next == ST_CLEAR)     result_valid_reg <= 1'b0;
      else if (state_next == ST_DONE) result_valid_reg <= 1'b1;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_DONE);
  assign result_valid = result_valid_reg;

  assign feed_valid   = (state_reg == ST_FEED);
  assign stream_phase = (state_reg == ST_FEED) || (state_reg == ST_DRAIN);
  assign a_gated      = feed_valid ? a_rd_data : '0;
  assign b_gated      = feed_valid ? b_rd_data : '0;

  // Lane i is delayed i cycles so operands meet diagonally inside the array.
  genvar gi;
  generate
    for (gi = 0; gi < array_dim; gi++) begin : g_lane
      localparam int LSB = lane_lsb(gi, array_dim, word_size);
      logic [word_size-1:0] a_skew, b_skew;
      logic                 a_v, b_v;

      if (gi == 0) begin : g_direct
        assign a_skew = a_gated[LSB +: word_size];
        assign b_skew = b_gated[LSB +: word_size];
        assign a_v    = feed_valid;
        assign b_v    = feed_valid;
      end else begin : g_delay
        skew_line #(.depth(gi), .word_size(word_size)) u_skew_a (
          .clk      (clk),
          .clear_n  (clear_n),
          .in_data  (a_gated[LSB +: word_size]),
          .in_valid (feed_valid),
          .out_data (a_skew),
          .out_valid(a_v)
        );
        skew_line #(.depth(gi), .word_size(word_size)) u_skew_b (
          .clk      (clk),
          .clear_n  (clear_n),
          .in_data  (b_gated[LSB +: word_size]),
          .in_valid (feed_valid),
          .out_data (b_skew),
          .out_valid(b_v)
        );
      end

      assign array_a[LSB +: word_size] = (a_v && stream_phase) ? a_skew : '0;
      assign array_b[LSB +: word_size] = (b_v && stream_phase) ? b_skew : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench: systolic_ctrl driving a behavioural 4x4 MAC array.
module tb_systolic_ctrl;

  localparam int WS = 16;
  localparam int DIM = 4;
  localparam int KW = 8;

  logic              clk;
  logic              clear_n;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy, done, result_valid, rd_en, array_clear;
  logic [KW-1:0]     rd_addr;
  logic [DIM*WS-1:0] a_rd_data, b_rd_data, array_a, array_b;

  systolic_ctrl #(.word_size(WS), .array_dim(DIM), .k_width(KW)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .result_valid(result_valid),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_data   (b_rd_data),
    .array_a     (array_a),
    .array_b     (array_b),
    .array_clear (array_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [DIM*WS-1:0] a_mem [256];
  logic [DIM*WS-1:0] b_mem [256];

  // Operand buffers with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rd_data <= a_mem[rd_addr];
      b_rd_data <= b_mem[rd_addr];
    end
  end

  function automatic logic [WS-1:0] lane(input logic [DIM*WS-1:0] v, input int i);
    return v[(DIM-1-i)*WS +: WS];
  endfunction

  // Behavioural output-stationary array: A flows east, B flows south.
  logic [31:0]   acc [DIM][DIM];
  logic [WS-1:0] pa  [DIM][DIM];
  logic [WS-1:0] pb  [DIM][DIM];
  always @(posedge clk) begin
    logic [WS-1:0] ain, bin;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        ain = (j == 0) ? lane(array_a, i) : pa[i][j-1];
        bin = (i == 0) ? lane(array_b, j) : pb[i-1][j];
        if (array_clear) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(ain) * 32'(bin);
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
      end
    end
  end

  // Per-job observations gathered by run_job.
  int          done_cyc;
  logic [63:0] clear_mask, rden_mask, a3_mask, b2_mask;
  int          max_addr, arr_nz_cnt;
  logic        rv_done, rv_clear, busy_after;
  logic [31:0] acc_snap [DIM][DIM];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_job(input logic [KW-1:0] k, input int limit);
    cyc = 0; done_cyc = -1; clear_mask = '0; rden_mask = '0;
    a3_mask = '0; b2_mask = '0; max_addr = 0; arr_nz_cnt = 0;
    rv_done = 1'b0; rv_clear = 1'b1;
    start = 1'b1; k_len = k;
    while (done_cyc < 0 && cyc < limit) begin
      tick();
      if (cyc == 1) begin
        start = 1'b0;
        rv_clear = result_valid;
      end
      if (cyc < 64) begin
        clear_mask[cyc] = array_clear;
        rden_mask[cyc]  = rd_en;
        a3_mask[cyc]    = (lane(array_a, 3) != '0);
        b2_mask[cyc]    = (lane(array_b, 2) != '0);
      end
      if (rd_en && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (array_a != '0 || array_b != '0) arr_nz_cnt++;
      if (done) begin
        done_cyc = cyc;
        rv_done  = result_valid;
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) acc_snap[i][j] = acc[i][j];
      end
    end
    tick();
    busy_after = busy;
    $display("job K=%0d: done at cycle %0d", k, done_cyc);
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", result_valid); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    checks++; if (array_a !== '0) begin errors++; $display("FAIL reset_array_a: got %h want 0", array_a); end
    checks++; if (array_b !== '0) begin errors++; $display("FAIL reset_array_b: got %h want 0", array_b); end
    checks++; if (array_clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b want 0", array_clear); end
  endtask

  task automatic test_identity();
    for (int k = 0; k < DIM; k++)
      for (int i = 0; i < DIM; i++) begin
        a_mem[k][(DIM-1-i)*WS +: WS] = (i == k) ? 16'd1 : 16'd0;
        b_mem[k][(DIM-1-i)*WS +: WS] = 16'(DIM*k + i + 1);
      end
    run_job(8'd4, 40);
    checks++; if (done_cyc != 12) begin errors++; $display("FAIL ident_done_cycle: got %0d want 12", done_cyc); end
    checks++; if (rv_done !== 1'b1) begin errors++; $display("FAIL ident_rv_at_done: got %b want 1", rv_done); end
    checks++; if (rv_clear !== 1'b0) begin errors++; $display("FAIL ident_rv_in_clear: got %b want 0", rv_clear); end
    checks++; if (clear_mask !== 64'h2) begin errors++; $display("FAIL ident_clear_mask: got %h want 2", clear_mask); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ident_busy_idle: got %b want 0", busy_after); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL ident_rv_level: got %b want 1", result_valid); end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        checks++;
        if (acc_snap[i][j] !== 32'(DIM*i + j + 1)) begin
          errors++;
          $display("FAIL ident_pe_%0d_%0d: got %0d want %0d", i, j, acc_snap[i][j], DIM*i + j + 1);
        end
      end
  endtask

  task automatic test_k_zero();
    run_job(8'd0, 20);
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL k0_done_cycle: got %0d want 2", done_cyc); end
    checks++; if (clear_mask !== 64'h2) begin errors++; $display("FAIL k0_clear_mask: got %h want 2", clear_mask); end
    checks++; if (rden_mask !== 64'h2) begin errors++; $display("FAIL k0_rd_en_mask: got %h want 2", rden_mask); end
    checks++; if (arr_nz_cnt != 0) begin errors++; $display("FAIL k0_array_quiet: got %0d nonzero cycles want 0", arr_nz_cnt); end
    checks++; if (acc_snap[3][3] !== 32'd0 || acc_snap[0][0] !== 32'd0) begin
      errors++; $display("FAIL k0_results: got %0d/%0d want 0/0", acc_snap[0][0], acc_snap[3][3]);
    end
  endtask

  task automatic test_skew();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DIM; i++) begin
        a_mem[k][(DIM-1-i)*WS +: WS] = 16'(16*i + k + 1);
        b_mem[k][(DIM-1-i)*WS +: WS] = 16'(16*i + k + 2);
      end
    run_job(8'd3, 30);
    checks++; if (a3_mask !== 64'hE0) begin errors++; $display("FAIL skew_a_lane3: got %h want e0", a3_mask); end
    checks++; if (b2_mask !== 64'h70) begin errors++; $display("FAIL skew_b_lane2: got %h want 70", b2_mask); end
    checks++; if (done_cyc != 11) begin errors++; $display("FAIL skew_done_cycle: got %0d want 11", done_cyc); end
    // PE(1,2) = sum_k (16+k+1)*(32+k+2) = 17*34 + 18*35 + 19*36 = 1892
    checks++; if (acc_snap[1][2] !== 32'd1892) begin errors++; $display("FAIL skew_pe_1_2: got %0d want 1892", acc_snap[1][2]); end
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < 256; k++) begin
      a_mem[k] = {DIM{16'd1}};
      b_mem[k] = {DIM{16'd1}};
    end
    run_job(8'd255, 300);
    checks++; if (done_cyc != 263) begin errors++; $display("FAIL ones_done_cycle: got %0d want 263", done_cyc); end
    checks++; if (max_addr != 254) begin errors++; $display("FAIL ones_max_rd_addr: got %0d want 254", max_addr); end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        checks++;
        if (acc_snap[i][j] !== 32'd255) begin
          errors++; $display("FAIL ones_pe_%0d_%0d: got %0d want 255", i, j, acc_snap[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid_feed();
    cyc = 0; start = 1'b1; k_len = 8'd8;
    tick(); start = 1'b0;
    while (cyc < 5) tick();
    checks++; if (rd_addr === '0) begin errors++; $display("FAIL midrst_active: rd_addr got 0 want nonzero"); end
    clear_n = 1'b0;
    tick();
    test_reset();
    clear_n = 1'b1;
    tick();
    run_job(8'd8, 40);
    checks++; if (done_cyc != 16) begin errors++; $display("FAIL midrst_done_cycle: got %0d want 16", done_cyc); end
    checks++; if (clear_mask !== 64'h2) begin errors++; $display("FAIL midrst_clear_mask: got %h want 2", clear_mask); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] clr_m, done_m, busy_m;
    clr_m = '0; done_m = '0; busy_m = '0;
    cyc = 0; start = 1'b1; k_len = 8'd2;
    while (cyc < 26) begin
      tick();
      case (cyc)
        1, 4, 13: start = 1'b0;
        3, 8:     start = 1'b1;
        default: ;
      endcase
      clr_m[cyc]  = array_clear;
      done_m[cyc] = done;
      busy_m[cyc] = busy;
    end
    $display("back-to-back: done mask %h, clear mask %h", done_m, clr_m);
    checks++; if (clr_m !== 64'h1002) begin errors++; $display("FAIL b2b_clear_mask: got %h want 1002", clr_m); end
    checks++; if (done_m !== 64'h200400) begin errors++; $display("FAIL b2b_done_mask: got %h want 200400", done_m); end
    checks++; if (busy_m !== 64'h3FF7FE) begin errors++; $display("FAIL b2b_busy_mask: got %h want 3ff7fe", busy_m); end
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; k_len = '0;
    a_rd_data = '0; b_rd_data = '0;
    for (int k = 0; k < 256; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    cyc = 0;
    tick(); tick();
    test_reset();
    clear_n = 1'b1;
    tick();
    test_identity();
    test_k_zero();
    test_skew();
    test_all_ones();
    test_reset_mid_feed();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the array_dim × array_dim output-stationary systolic array of fixed-point MAC PEs. On `start` it clears the array, streams K operand vectors from the A and B operand buffers with per-lane diagonal skew onto the west (A) and north (B) array edges, and drains the wavefront. It then flags that every PE accumulator holds its final dot product. It sits between the operand buffers and the array and owns the array `clear`.

## Interface
- `word_size`, 16: operand width per lane.
- `array_dim`, 4: array rows = columns = number of lanes.
- `k_width`, 8: width of K count and buffer address; max K = 2^k_width − 1.

- `clk`  in  1  rising-edge clock.
- `clear_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request a new matrix product; sampled in IDLE only.
- `k_len`  in  k_width  inner dimension K; latched on accepted start.
- `busy`  out  1  high from the cycle after start acceptance until DONE inclusive.
- `done`  out  1  one-cycle pulse; all PE outputs are final.
- `result_valid`  out  1  level; set with done, cleared in CLEAR of the next job.
- `rd_en`  out  1  operand buffer read strobe (both buffers).
- `rd_addr`  out  k_width  operand vector index k (shared A/B address).
- `a_rd_data`  in  array_dim*word_size  A column k, lane i = row i; returned 1 cycle after rd_en.
- `b_rd_data`  in  array_dim*word_size  B row k, lane j = column j; 1-cycle latency.
- `array_a`  out  array_dim*word_size  skewed west-edge inputs, lane i to row i.
- `array_b`  out  array_dim*word_size  skewed north-edge inputs, lane j to column j.
- `array_clear`  out  1  drives the synchronous `clear` of every PE.
- Lane packing: lane 0 occupies the most-significant word (vectors are ascending `[0:…]`).

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: `start`=1 → latch `k_len` into `k_reg` → CLEAR. `start` in any other state is ignored.
- CLEAR (1 cycle): `array_clear`=1, `result_valid`←0, `rd_en`=1, `rd_addr`=0. If `k_reg`=0 → DONE; else → FEED.
- FEED (`k_reg` cycles, counter k = 0…K−1): buffer data for index k is present; issue `rd_en`=1, `rd_addr`=k+1 while k+1<K, else `rd_en`=0. At k=K−1 → DRAIN.
- Skew: lane i of A passes through i register stages; lane j of B passes through j stages. Lane 0 is combinational from the gated buffer data.
- Each stage carries a valid bit. Invalid words are driven as zero, so post-stream MACs add 0 and PE outputs remain stable.
- DRAIN: counter runs 2·(array_dim−1) cycles → DONE.
- DONE (1 cycle): `done`=1, `result_valid`←1 → IDLE.
- `array_a`/`array_b` are zero in IDLE, CLEAR and DONE, and whenever the lane valid bit is 0.

## Timing
- Start sampled at edge ending cycle 0. CLEAR is cycle 1. FEED is cycles 2…K+1. DRAIN is cycles K+2…K+2·array_dim−1. DONE/`done` is cycle K+2·array_dim.
- K=0: `done` at cycle 2; results are zero.
- PE(i,j) sees operand k at cycle 2+k+i+j. Its final accumulate lands at the edge ending cycle K+1+2·(array_dim−1), so outputs are valid exactly in the DONE cycle.
- Back-to-back: `start` held high re-arms in the IDLE cycle after DONE; minimum job period K+2·array_dim+1.
- Reset (any state, mid-job included): state IDLE, counters 0, skew registers 0. All outputs 0: `busy`, `done`, `result_valid`, `rd_en`, `rd_addr`, `array_a`, `array_b`, `array_clear`. A partial job is abandoned, and the next start clears the array.

## Structure
- Shared package `systolic_pkg`: state enum, state encoding width, lane-slicing helper constants.
- One sub-module `skew_line` (parameter depth, word_size): depth-stage data+valid shift register with async active-low reset. It is instantiated array_dim−1 times per edge; depth 0 is a wire.
- Controller FSM, K counter and drain counter live in `systolic_ctrl`.

## Test plan
- Reset mid-FEED (array_dim=4, K=8, assert `clear_n`=0 in cycle 5) → all outputs 0 next cycle. A fresh start then completes normally with `done` at cycle 16.
- Identity × B, array_dim=4, K=4, B rows 1..16 → `done` at cycle 12, array holds B exactly, `result_valid`=1.
- K=0 → `array_clear` in cycle 1, `done` in cycle 2, array outputs all 0, `rd_en` only in CLEAR.
- All-ones A and B, K=255 → every PE = 255, `done` at cycle 263, and `rd_addr` never exceeds 254.
- Skew check, K=3: monitor `array_a` lane 3 → nonzero exactly cycles 5–7; `array_b` lane 2 → cycles 4–6.
- `start` pulsed during FEED and held through DONE → mid-job pulse ignored; second job begins CLEAR on the cycle after IDLE.
